// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage. It accepts one request at a time,
// drives the data RAM with big-endian byte lanes, and returns extended
// load data or SC status. It also owns the LL/SC link bit, checks
// alignment, and aborts a load if the RAM never responds.
module mem_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        llbit_clr_i,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ready_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic [1:0]  resp_err_o,
  output logic        stall_o,
  output logic        llbit_o
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;
  localparam logic [3:0] OP_LL  = 4'd8;
  localparam logic [3:0] OP_SC  = 4'd9;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_OP    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        op_reg, op_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              llbit_reg, llbit_next;
  logic [31:0]       data_reg, data_next;
  logic [1:0]        err_reg, err_next;

  function automatic logic is_byte(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  // Lane enables: byte lane 0 of the address lives in bits [31:24].
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
    if (is_byte(op))      return 4'b1000 >> a;
    else if (is_half(op)) return a[1] ? 4'b0011 : 4'b1100;
    else                  return 4'b1111;
  endfunction

  // Stores place the datum on every lane so that sel alone picks the target bytes.
  function automatic logic [31:0] lane_data(input logic [3:0] op, input logic [31:0] d);
    if (is_byte(op))      return {4{d[7:0]}};
    else if (is_half(op)) return {2{d[15:0]}};
    else                  return d;
  endfunction

  // Pick the addressed byte/half out of the RAM word and extend it.
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = a[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      op_reg    <= 4'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      cnt_reg   <= '0;
      llbit_reg <= 1'b0;
      data_reg  <= 32'd0;
      err_reg   <= ERR_OK;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= cnt_next;
      llbit_reg <= llbit_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic and all outputs, decoded from the current state.
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    cnt_next     = cnt_reg;
    llbit_next   = llbit_reg;
    data_next    = data_reg;
    err_next     = err_reg;

    req_ready_o  = 1'b0;
    ram_ce_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_addr_o   = 32'd0;
    ram_sel_o    = 4'd0;
    ram_data_o   = 32'd0;
    resp_valid_o = 1'b0;
    resp_data_o  = 32'd0;
    resp_err_o   = ERR_OK;
    stall_o      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = req_valid_i;
        cnt_next    = '0;
        if (req_valid_i) begin
          op_next    = op_i;
          addr_next  = addr_i;
          wdata_next = wdata_i;
          data_next  = 32'd0;
          err_next   = ERR_OK;
          if (op_i > OP_SC) begin
            err_next   = ERR_OP;
            state_next = S_RESP;
          end else if ((is_half(op_i) && addr_i[0]) ||
                       (!is_byte(op_i) && !is_half(op_i) && (addr_i[1:0] != 2'd0))) begin
            err_next   = ERR_ALIGN;
            state_next = S_RESP;
          end else if ((op_i == OP_SC) && !llbit_reg) begin
            // Link already broken: report failure without touching the RAM.
            state_next = S_RESP;
          end else begin
            state_next = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        stall_o    = 1'b1;
        ram_ce_o   = 1'b1;
        ram_addr_o = {addr_reg[31:2], 2'b00};
        ram_sel_o  = lane_sel(op_reg, addr_reg[1:0]);
        ram_data_o = lane_data(op_reg, wdata_reg);
        if (is_store(op_reg)) begin
          ram_we_o   = 1'b1;
          state_next = S_RESP;
          if (op_reg == OP_SC) begin
            data_next  = 32'd1;
            llbit_next = 1'b0;
          end
        end else if (ram_ready_i) begin
          data_next  = load_extract(op_reg, addr_reg[1:0], ram_data_i);
          state_next = S_RESP;
          if (op_reg == OP_LL) llbit_next = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          data_next  = 32'd0;
          err_next   = ERR_TMO;
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_data_o  = data_reg;
        resp_err_o   = err_reg;
        state_next   = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase

    // An external clear overrides any LL set in the same cycle.
    if (llbit_clr_i) llbit_next = 1'b0;
  end

  assign llbit_o = llbit_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small behavioural RAM and a response
// scoreboard: expected results are queued when a request is driven and
// checked when resp_valid_o appears.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        llbit_clr_i = 1'b0;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic        ram_ready_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_err_o;
  logic        stall_o;
  logic        llbit_o;

  mem_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .llbit_clr_i(llbit_clr_i),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .stall_o(stall_o), .llbit_o(llbit_o)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: 64 words, optional read delay, byte-lane writes.
  logic [31:0] mem [0:63];
  logic        ready_en = 1'b1;
  int          ready_dly = 0;
  int          acc_cnt = 0;
  int          ce_cnt = 0;
  int          we_cnt = 0;
  int          stall_bad = 0;
  logic [3:0]  last_sel = 4'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [31:0] last_addr = 32'd0;

  assign ram_data_i  = mem[ram_addr_o[7:2]];
  assign ram_ready_i = ready_en && ram_ce_o && !ram_we_o && (acc_cnt >= ready_dly);

  // RAM write port plus bookkeeping of RAM activity and stall behaviour.
  always @(posedge clk) begin
    if (ram_ce_o && !ram_we_o) acc_cnt <= acc_cnt + 1;
    else                       acc_cnt <= 0;
    if (ram_ce_o) ce_cnt <= ce_cnt + 1;
    if (ram_ce_o && !stall_o) stall_bad <= stall_bad + 1;
    if (ram_ce_o && ram_we_o) begin
      we_cnt     <= we_cnt + 1;
      last_sel   <= ram_sel_o;
      last_wdata <= ram_data_o;
      last_addr  <= ram_addr_o;
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request, then wait (bounded) for its response and score it.
  task automatic do_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] ed, input logic [1:0] ee,
                        input int el);
    exp_t e;
    int   n;
    exp_q.push_back('{data: ed, err: ee, lat: el});
    req_valid_i = 1'b1;
    op_i        = op;
    addr_i      = addr;
    wdata_i     = wd;
    #1;
    chk({tag, ".ready"}, {31'd0, req_ready_o}, 32'd1);
    chk({tag, ".stall_acc"}, {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 1;
    while (!resp_valid_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    if (!resp_valid_o) begin
      chk({tag, ".resp_seen"}, 32'd0, 32'd1);
    end else begin
      chk({tag, ".data"}, resp_data_o, e.data);
      chk({tag, ".err"}, {30'd0, resp_err_o}, {30'd0, e.err});
      chk({tag, ".lat"}, n, e.lat);
      chk({tag, ".stall_resp"}, {31'd0, stall_o}, 32'd0);
      $display("[TB] %s op=%0d addr=0x%08h data=0x%08h err=%0d lat=%0d",
               tag, op, addr, resp_data_o, resp_err_o, n);
    end
    @(posedge clk); #1;
  endtask

  int ce0, we0;

  initial begin
    // Reset state.
    #2;
    chk("rst.ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst.ce", {31'd0, ram_ce_o}, 32'd0);
    chk("rst.stall", {31'd0, stall_o}, 32'd0);
    chk("rst.llbit", {31'd0, llbit_o}, 32'd0);
    chk("rst.resp_valid", {31'd0, resp_valid_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // SW: one write cycle, full lanes.
    ce0 = ce_cnt; we0 = we_cnt;
    do_req("sw10", 4'd7, 32'h10, 32'hDEADBEEF, 32'd0, 2'd0, 2);
    chk("sw10.ce_cycles", ce_cnt - ce0, 1);
    chk("sw10.we_cycles", we_cnt - we0, 1);
    chk("sw10.sel", {28'd0, last_sel}, 32'hF);
    chk("sw10.wdata", last_wdata, 32'hDEADBEEF);
    do_req("sw20", 4'd7, 32'h20, 32'h80FF1234, 32'd0, 2'd0, 2);

    // Loads with extension.
    do_req("lb20", 4'd0, 32'h20, 32'd0, 32'hFFFFFF80, 2'd0, 2);
    do_req("lbu21", 4'd1, 32'h21, 32'd0, 32'h000000FF, 2'd0, 2);
    do_req("lh22", 4'd2, 32'h22, 32'd0, 32'h00001234, 2'd0, 2);
    do_req("lhu20", 4'd3, 32'h20, 32'd0, 32'h000080FF, 2'd0, 2);
    do_req("lb23", 4'd0, 32'h23, 32'd0, 32'h00000034, 2'd0, 2);
    ready_dly = 3;
    do_req("lw20_dly", 4'd4, 32'h20, 32'd0, 32'h80FF1234, 2'd0, 5);
    ready_dly = 0;

    // SB lane replication, then read back the merged word.
    do_req("sb13", 4'd5, 32'h13, 32'h000000AB, 32'd0, 2'd0, 2);
    chk("sb13.sel", {28'd0, last_sel}, 32'h1);
    chk("sb13.wdata", last_wdata, 32'hABABABAB);
    chk("sb13.addr", last_addr, 32'h10);
    do_req("lw10", 4'd4, 32'h10, 32'd0, 32'hDEADBEAB, 2'd0, 2);

    // Misaligned and reserved: no RAM access at all.
    ce0 = ce_cnt;
    do_req("lw12_mis", 4'd4, 32'h12, 32'd0, 32'd0, 2'd1, 1);
    do_req("lh21_mis", 4'd2, 32'h21, 32'd0, 32'd0, 2'd1, 1);
    do_req("rsv", 4'd12, 32'h10, 32'd0, 32'd0, 2'd3, 1);
    chk("mis.no_ce", ce_cnt - ce0, 0);

    // LL/SC success.
    do_req("sw40", 4'd7, 32'h40, 32'h11223344, 32'd0, 2'd0, 2);
    do_req("ll40", 4'd8, 32'h40, 32'd0, 32'h11223344, 2'd0, 2);
    chk("ll40.llbit", {31'd0, llbit_o}, 32'd1);
    we0 = we_cnt;
    do_req("sc40_ok", 4'd9, 32'h40, 32'h55667788, 32'd1, 2'd0, 2);
    chk("sc40_ok.write", we_cnt - we0, 1);
    chk("sc40_ok.llbit", {31'd0, llbit_o}, 32'd0);
    do_req("lw40", 4'd4, 32'h40, 32'd0, 32'h55667788, 2'd0, 2);

    // LL, external clear, SC fails without writing.
    do_req("ll40b", 4'd8, 32'h40, 32'd0, 32'h55667788, 2'd0, 2);
    llbit_clr_i = 1'b1;
    @(posedge clk); #1;
    llbit_clr_i = 1'b0;
    chk("clr.llbit", {31'd0, llbit_o}, 32'd0);
    ce0 = ce_cnt; we0 = we_cnt;
    do_req("sc40_fail", 4'd9, 32'h40, 32'hCAFEF00D, 32'd0, 2'd0, 1);
    chk("sc40_fail.no_ce", ce_cnt - ce0, 0);
    chk("sc40_fail.no_we", we_cnt - we0, 0);

    // Timeout: 16 ACCESS cycles, stall held the whole time.
    ready_en = 1'b0;
    ce0 = ce_cnt;
    do_req("lw_tmo", 4'd4, 32'h10, 32'd0, 32'd0, 2'd2, 17);
    chk("tmo.access_cycles", ce_cnt - ce0, 16);
    chk("tmo.stall", stall_bad, 0);

    // Asynchronous reset in the middle of a load.
    req_valid_i = 1'b1; op_i = 4'd4; addr_i = 32'h20;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("arst.pre_ce", {31'd0, ram_ce_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst.ce", {31'd0, ram_ce_o}, 32'd0);
    chk("arst.ready", {31'd0, req_ready_o}, 32'd1);
    chk("arst.stall", {31'd0, stall_o}, 32'd0);
    chk("arst.addr", ram_addr_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    ready_en = 1'b1;
    @(posedge clk); #1;
    do_req("lw20_post", 4'd4, 32'h20, 32'd0, 32'h80FF1234, 2'd0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
